// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor
//
// Turns one 256-bit line transaction from the cache arbiter into a 64-bit,
// four-beat burst on the memory bus.
// - Line reads are assembled beat by beat into rbuf.
// - Line writes are sent out from a copy of the line latched at request time.
// - Completion is reported to the arbiter as a single-cycle resp_o pulse.
//
// Handshake:
// - Arbiter side: read_i/write_i are levels held until resp_o. They are
//   sampled only in IDLE, so a request still high during the resp_o cycle
//   does not start a second transfer.
// - Memory side: read_o/write_o stay high for the whole burst. Each cycle in
//   which resp_i is high transfers exactly one beat. Beat 0 is line bits
//   [63:0] and beat 3 is line bits [255:192].
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   line_i     write line from arbiter
//   address_i  line address from arbiter
//   read_i     line read request
//   write_i    line write request (takes priority over read_i)
//   line_o     assembled read line (always rbuf)
//   resp_o     one-cycle completion pulse
//   burst_i    read beat from memory
//   burst_o    write beat to memory (0 outside WRITE)
//   address_o  line-aligned burst address
//   read_o     burst read request
//   write_o    burst write request
//   resp_i     memory beat strobe
//   dbg_state  current FSM state, for checkers

module line_burst_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] line_i,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic [255:0] line_o,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state;
  logic [1:0]     cnt;
  logic [1:0]     cnt_nxt;
  logic [255:0]   rbuf;
  logic [255:0]   wbuf;
  logic [31:0]    abuf;

  assign cnt_nxt   = cnt + 2'd1;
  assign line_o    = rbuf;
  assign address_o = abuf;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 2'd0;
      rbuf    <= '0;
      wbuf    <= '0;
      abuf    <= '0;
      burst_o <= '0;
      read_o  <= 1'b0;
      write_o <= 1'b0;
      resp_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          resp_o <= 1'b0;
          if (write_i) begin
            wbuf    <= line_i;
            abuf    <= {address_i[31:5], 5'b0};
            cnt     <= 2'd0;
            // Beat 0 must be on the bus in the same cycle write_o rises.
            burst_o <= line_i[63:0];
            write_o <= 1'b1;
            state   <= S_WRITE;
          end else if (read_i) begin
            abuf    <= {address_i[31:5], 5'b0};
            cnt     <= 2'd0;
            read_o  <= 1'b1;
            state   <= S_READ;
          end
        end

        S_READ: begin
          if (resp_i) begin
            rbuf[{cnt, 6'd0} +: 64] <= burst_i;
            if (cnt == 2'd3) begin
              // Clear explicitly rather than letting the 2-bit counter wrap.
              cnt    <= 2'd0;
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= S_DONE;
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end

        S_WRITE: begin
          if (resp_i) begin
            if (cnt == 2'd3) begin
              cnt     <= 2'd0;
              burst_o <= '0;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= S_DONE;
            end else begin
              // Present the next beat. It stays on the bus until accepted.
              cnt     <= cnt_nxt;
              burst_o <= wbuf[{cnt_nxt, 6'd0} +: 64];
            end
          end
        end

        S_DONE: begin
          resp_o <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Testbench for line_burst_adaptor.
// The bench plays the role of both the arbiter and the memory. Every
// transaction is checked cycle by cycle against a transaction-level model:
// - the expected address is the line address with its low five bits cleared;
// - the expected write beats are the line cut into 64-bit slices;
// - the expected read line is the set of beats that memory returned;
// - resp_o is expected exactly one cycle after the fourth accepted beat.

module tb_line_burst_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  // Model state: the line that line_o should show outside an active read.
  logic [255:0] rbuf_model;
  // Scoreboard of write beats still to be accepted, oldest first.
  logic [63:0]  exp_q[$];

  line_burst_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Driver: one full line transaction. Called at a negedge with the DUT idle.
  // pat/pat_len force the first pat_len resp_i values; after that resp_i is
  // random, high with probability 1/(maxgap+1).
  task automatic do_txn(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [255:0] wline, input logic [255:0] rline,
                        input logic [31:0] exp_addr, input logic [15:0] pat,
                        input int pat_len, input int maxgap);
    logic         is_wr;
    logic [255:0] exp_line;
    int           beat;
    int           cyc;
    is_wr = wr;
    exp_q.delete();
    if (is_wr) for (int k = 0; k < 4; k++) exp_q.push_back(wline[k*64 +: 64]);
    write_i   = wr;
    read_i    = rd;
    address_i = addr;
    line_i    = wline;
    resp_i    = 1'b0;
    @(posedge clk); @(negedge clk);
    // Changes after the request is sampled must not reach the burst.
    address_i = $urandom;
    line_i    = {8{$urandom}};
    beat = 0;
    cyc  = 0;
    while (beat < 4 && cyc < 100) begin
      chk("read_o_busy", read_o, !is_wr);
      chk("write_o_busy", write_o, is_wr);
      chk("resp_o_busy", resp_o, 1'b0);
      chk("address_o", address_o, exp_addr);
      exp_line = rbuf_model;
      if (!is_wr) for (int k = 0; k < beat; k++) exp_line[k*64 +: 64] = rline[k*64 +: 64];
      chk("line_o_busy", line_o, exp_line);
      if (is_wr) chk("burst_o", burst_o, exp_q[0]);
      resp_i  = (cyc < pat_len) ? pat[cyc] : ($urandom_range(0, maxgap) == 0);
      burst_i = resp_i ? rline[beat*64 +: 64] : {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
      if (resp_i) begin
        beat++;
        if (is_wr) void'(exp_q.pop_front());
      end
      cyc++;
    end
    if (beat < 4) begin
      checks++;
      failures++;
      $display("FAIL burst_timeout actual=%0d beats expected=4", beat);
    end
    if (!is_wr) rbuf_model = rline;
    // Cycle after the 4th beat: the completion pulse.
    chk("resp_o_done", resp_o, 1'b1);
    chk("read_o_done", read_o, 1'b0);
    chk("write_o_done", write_o, 1'b0);
    chk("burst_o_done", burst_o, 64'd0);
    chk("line_o_done", line_o, rbuf_model);
    // Requests stay high through the completion cycle; memory strobes are ignored.
    resp_i  = $urandom_range(0, 1);
    burst_i = {$urandom, $urandom};
    @(posedge clk); @(negedge clk);
    read_i  = 1'b0;
    write_i = 1'b0;
    resp_i  = 1'b0;
    chk("resp_o_single", resp_o, 1'b0);
    chk("read_o_no_retrigger", read_o, 1'b0);
    chk("write_o_no_retrigger", write_o, 1'b0);
    chk("line_o_idle", line_o, rbuf_model);
    @(posedge clk); @(negedge clk);
    chk("read_o_idle", read_o, 1'b0);
    chk("write_o_idle", write_o, 1'b0);
  endtask

  typedef struct {
    logic         wr;
    logic         rd;
    logic [31:0]  addr;
    logic [255:0] wline;
    logic [255:0] rline;
    logic [15:0]  pat;
    int           pat_len;
    logic [31:0]  exp_addr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    // Directed vectors
    vecs[0] = '{wr: 1'b0, rd: 1'b1, addr: 32'h1234_567F, wline: '0,
                rline: {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
                pat: 16'h000F, pat_len: 4, exp_addr: 32'h1234_5660};
    // Memory strobe pattern 1,0,0,1,1,0,1 (cycle 0 in bit 0).
    vecs[1] = '{wr: 1'b1, rd: 1'b0, addr: 32'hCAFE_BABF,
                wline: {64'hDEAD_0003_BEEF_3333, 64'hDEAD_0002_BEEF_2222,
                        64'hDEAD_0001_BEEF_1111, 64'hDEAD_0000_BEEF_0000},
                rline: '0, pat: 16'b0000_0000_0101_1001, pat_len: 7,
                exp_addr: 32'hCAFE_BAA0};
    // Simultaneous read and write is treated as a write.
    vecs[2] = '{wr: 1'b1, rd: 1'b1, addr: 32'hFFFF_FFFF,
                wline: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                        64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_F0F0_00FF_FF00},
                rline: '0, pat: 16'h0000, pat_len: 2, exp_addr: 32'hFFFF_FFE0};
    // Read after writes: line_o keeps the old read data until the first beat.
    vecs[3] = '{wr: 1'b0, rd: 1'b1, addr: 32'h0000_001F, wline: '0,
                rline: {64'hBBBB_0003_0000_0003, 64'hBBBB_0002_0000_0002,
                        64'hBBBB_0001_0000_0001, 64'hBBBB_0000_0000_0000},
                pat: 16'h0000, pat_len: 3, exp_addr: 32'h0000_0000};

    rst        = 1'b0;
    line_i     = '0;
    address_i  = '0;
    read_i     = 1'b0;
    write_i    = 1'b0;
    burst_i    = '0;
    resp_i     = 1'b0;
    rbuf_model = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_address_o", address_o, 32'd0);
    chk("rst_burst_o", burst_o, 64'd0);
    chk("rst_line_o", line_o, 256'd0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);

    for (int i = 0; i < 4; i++)
      do_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wline, vecs[i].rline,
             vecs[i].exp_addr, vecs[i].pat, vecs[i].pat_len, 2);

    // Asynchronous reset after two beats of a read.
    read_i    = 1'b1;
    address_i = 32'h0000_0100;
    @(posedge clk); @(negedge clk);
    resp_i  = 1'b1;
    burst_i = 64'hAAAA_AAAA_AAAA_AAAA;
    @(posedge clk); @(negedge clk);
    burst_i = 64'h5555_5555_5555_5555;
    @(posedge clk); @(negedge clk);
    resp_i = 1'b0;
    chk("pre_abort_read_o", read_o, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort_read_o", read_o, 1'b0);
    chk("abort_write_o", write_o, 1'b0);
    chk("abort_resp_o", resp_o, 1'b0);
    chk("abort_address_o", address_o, 32'd0);
    chk("abort_burst_o", burst_o, 64'd0);
    chk("abort_line_o", line_o, 256'd0);
    read_i = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_no_resp", resp_o, 1'b0);
    @(negedge clk);
    rst        = 1'b1;
    rbuf_model = '0;
    @(posedge clk); @(negedge clk);
    do_txn(1'b0, 1'b1, 32'h0000_0100, '0,
           {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
            64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001},
           32'h0000_0100, 16'h0000, 0, 1);

    // Randomized transactions.
    for (int i = 0; i < 30; i++) begin
      logic         r_wr;
      logic         r_rd;
      logic [31:0]  r_addr;
      logic [255:0] r_wline;
      logic [255:0] r_rline;
      r_wr    = $urandom_range(0, 1);
      r_rd    = r_wr ? 1'($urandom_range(0, 1)) : 1'b1;
      r_addr  = $urandom;
      r_wline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      r_rline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_txn(r_wr, r_rd, r_addr, r_wline, r_rline, r_addr & ~32'h1F, 16'h0000, 0, 3);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
